// File: rtl/exp_request_ctrl.sv
// Exception-request initiator: debounces three buttons into sticky pending events and
// presents them one at a time to the CPU, holding each request until HasExp acknowledges it.

module exp_db_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);
  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            flip;

  always_comb begin
    flip     = (sync_q[1] != stable_q) && (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
    stable_d = flip ? ~stable_q : stable_q;
    cnt_d    = ((sync_q[1] == stable_q) || flip) ? '0 : cnt_q + DB_W'(1);
    rise_o   = flip & sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module exp_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic       ack,
  input  logic       expblock,
  output logic       expsrc0,
  output logic       expsrc1,
  output logic       expsrc2,
  output logic [2:0] pending,
  output logic       busy,
  output logic [7:0] req_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] src_q, src_d;
  logic [2:0] pending_q, pending_d;
  logic [7:0] req_cnt_q, req_cnt_d;
  logic [2:0] rise, clr;

  for (genvar i = 0; i < 3; i++) begin : g_lane
    exp_db_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[i]),
      .rise_o (rise[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    src_d     = src_q;
    clr       = '0;
    req_cnt_d = req_cnt_q;
    case (state_q)
      IDLE: if (pending_q != '0 && !expblock) begin
        if (pending_q[0])      sel_d = 2'd0;
        else if (pending_q[1]) sel_d = 2'd1;
        else                   sel_d = 2'd2;
        src_d   = 3'b001 << sel_d;
        state_d = REQ;
      end
      REQ: if (ack) begin
        clr       = 3'b001 << sel_q;
        src_d     = '0;
        req_cnt_d = req_cnt_q + 8'd1;
        state_d   = WAIT_REL;
      end
      WAIT_REL: if (!ack) state_d = IDLE;
      default: begin
        state_d = IDLE;
        src_d   = '0;
      end
    endcase
    // a new event landing on the clearing edge must survive
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      src_q     <= '0;
      pending_q <= '0;
      req_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  assign expsrc0 = src_q[0];
  assign expsrc1 = src_q[1];
  assign expsrc2 = src_q[2];
  assign pending = pending_q;
  assign busy    = (state_q != IDLE);
  assign req_cnt = req_cnt_q;
endmodule

// File: tb/tb_exp_request_ctrl.sv
// Bench for exp_request_ctrl: expected request channels are queued as presses are driven
// and popped when a request line rises; cycle-exact checks cover latency and FSM boundaries.

module tb_exp_request_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic       ack, expblock;
  logic       expsrc0, expsrc1, expsrc2, busy;
  logic [2:0] pending;
  logic [7:0] req_cnt;
  logic [2:0] src, src_prev;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_cnt;

  exp_request_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .ack(ack), .expblock(expblock),
    .expsrc0(expsrc0), .expsrc1(expsrc1), .expsrc2(expsrc2),
    .pending(pending), .busy(busy), .req_cnt(req_cnt)
  );

  always #5 clk = ~clk;
  assign src = {expsrc2, expsrc1, expsrc0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k = 0;
    while (src == 3'b000 && k < 60) begin
      tick(1);
      k++;
    end
    chk("req_timeout", (src != 3'b000), 1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
  endtask

  // scoreboard: every rising request must match the oldest queued channel
  initial src_prev = '0;
  always @(negedge clk) begin
    if (src_prev == 3'b000 && src != 3'b000) begin
      if (exp_q.size() == 0) chk("unexp_req", src, 0);
      else chk("sb_src", src, 32'd1 << exp_q.pop_front());
    end
    if (src != 3'b000) chk("onehot", $countones(src), 1);
    src_prev = src;
  end

  initial begin
    reset = 1'b1; btn = '0; ack = 1'b0; expblock = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_src", src, 0);
    chk("rst_pend", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", req_cnt, 0);
    exp_cnt = 0;

    // single press, exact latency
    btn = 3'b001;
    exp_q.push_back(0);
    tick(5);
    chk("lat_pend_e5", pending, 0);
    tick(1);
    chk("lat_pend_e6", pending, 3'b001);
    chk("lat_src_e6", src, 0);
    tick(1);
    chk("lat_src_e7", src, 3'b001);
    chk("lat_busy", busy, 1);
    tick(2);
    chk("hold_src", src, 3'b001);
    ack = 1'b1;
    tick(1);
    exp_cnt++;
    chk("ack_src", src, 0);
    chk("ack_pend", pending, 0);
    chk("ack_cnt", req_cnt, exp_cnt);
    chk("wrel_busy", busy, 1);
    ack = 1'b0;
    tick(1);
    chk("idle_busy", busy, 0);
    btn = '0;
    tick(10);
    chk("release_pend", pending, 0);

    // glitch rejection and accumulation while blocked
    expblock = 1'b1;
    btn = 3'b010;
    tick(DB - 1);
    btn = '0;
    tick(10);
    chk("glitch_pend", pending, 0);
    chk("glitch_src", src, 0);
    btn = 3'b010;
    tick(DB + 2);
    chk("held_pend", pending, 3'b010);
    btn = 3'b100;
    tick(DB + 8);
    btn = 3'b001;
    tick(DB + 2);
    btn = '0;
    chk("blk_pend", pending, 3'b111);
    chk("blk_src", src, 0);
    chk("blk_busy", busy, 0);
    tick(10);

    // priority order after unblocking: 0, 1, 2
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    expblock = 1'b0;
    tick(1);
    chk("unblk_src", src, 3'b001);
    expblock = 1'b1;
    tick(1);
    chk("blk_in_req", src, 3'b001);
    expblock = 1'b0;
    ack_pulse(); exp_cnt++;
    tick(1);
    chk("prio1_src", src, 3'b010);
    ack_pulse(); exp_cnt++;
    tick(1);
    chk("prio2_src", src, 3'b100);
    ack_pulse(); exp_cnt++;
    chk("prio_cnt", req_cnt, exp_cnt);
    chk("prio_pend", pending, 0);

    // ack held 3 cycles while a new event lands during WAIT_REL
    btn = 3'b001;
    exp_q.push_back(0);
    wait_req();
    btn = '0;
    tick(10);
    chk("req_hold_long", src, 3'b001);
    btn = 3'b001;
    exp_q.push_back(0);
    tick(3);
    ack = 1'b1;
    tick(1); exp_cnt++;
    chk("ah_pend_clr", pending, 0);
    tick(2);
    chk("ah_pend_new", pending, 3'b001);
    chk("ah_src", src, 0);
    chk("ah_busy", busy, 1);
    ack = 1'b0;
    tick(1);
    chk("ah_idle_src", src, 0);
    chk("ah_idle_busy", busy, 0);
    tick(1);
    chk("ah_rereq", src, 3'b001);

    // event set on the same edge its channel is cleared: set wins
    btn = '0;
    tick(10);
    btn = 3'b001;
    exp_q.push_back(0);
    tick(5);
    ack = 1'b1;
    tick(1); exp_cnt++;
    chk("sw_pend", pending, 3'b001);
    chk("sw_src", src, 0);
    ack = 1'b0;
    tick(2);
    chk("sw_rereq", src, 3'b001);
    ack_pulse(); exp_cnt++;
    btn = '0;
    tick(10);
    chk("cnt_mid", req_cnt, exp_cnt);

    // run req_cnt through its wrap
    while (exp_cnt < 257) begin
      btn = 3'b001;
      exp_q.push_back(0);
      wait_req();
      btn = '0;
      ack_pulse(); exp_cnt++;
      tick(8);
      if (exp_cnt == 255 || exp_cnt == 256) chk("cnt_wrap", req_cnt, exp_cnt % 256);
    end
    chk("cnt_after_wrap", req_cnt, exp_cnt % 256);

    // reset while channel 2 is requesting
    btn = 3'b100;
    exp_q.push_back(2);
    wait_req();
    chk("pre_rst_src", src, 3'b100);
    btn = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_src", src, 0);
    chk("mrst_pend", pending, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", req_cnt, 0);
    tick(15);
    chk("post_rst_src", src, 0);
    chk("post_rst_pend", pending, 0);
    chk("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exp_request_ctrl.md
Name: exp_request_ctrl

Overview:
- Initiator end of the CPU exception-request interface: turns raw board buttons into clean, one-at-a-time requests on the CPU's expsrc0/expsrc1/expsrc2 inputs.
- Consumes the CPU's HasExp (acknowledge) and ExpBlock (masked) status.
- Per channel: synchronises and debounces, latches sticky pending events, arbitrates by fixed priority, and holds each request until the CPU acknowledges it.
- Sits beside single_cycle_cpu at board top level.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from its stable level before the stable level flips. Minimum 1.
- DB_W, 20: debounce counter width. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- btn  input  3  raw asynchronous buttons; bit i feeds channel i.
- ack  input  1  CPU HasExp; high while the CPU is taking an exception.
- expblock  input  1  CPU ExpBlock; high means no new request may be raised.
- expsrc0  output  1  request line, channel 0 (highest priority).
- expsrc1  output  1  request line, channel 1.
- expsrc2  output  1  request line, channel 2 (lowest priority).
- pending  output  3  latched, not-yet-served events per channel.
- busy  output  1  high whenever the FSM is not in IDLE.
- req_cnt  output  8  count of acknowledged requests.

Behaviour:
- Reset: one clk edge with reset high clears all state. That includes synchronisers, stable levels, debounce counters, pending, the FSM (to IDLE), req_cnt, and all outputs, which become 0. Reset overrides everything, including mid-request: expsrc drops after that edge.
- Synchroniser: two flops per channel. The second flop is sync[i].
- Debounce, per channel:
  - If sync[i] == stable[i], the counter resets to 0.
  - Otherwise the counter increments. On the edge where the DEBOUNCE_CYCLES-th consecutive differing sample is seen, stable[i] flips and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- Event: the rising flip of stable[i] sets pending[i] on the same edge. A falling flip does nothing.
- Latency: btn[i] rises before edge 1 → pending[i] set at edge 2+DEBOUNCE_CYCLES → expsrc_i high at edge 3+DEBOUNCE_CYCLES (FSM in IDLE, not blocked).
- FSM states: IDLE, REQ, WAIT_REL.
- IDLE:
  - If pending != 0 and expblock == 0: choose sel = lowest-index set bit, drive expsrc_sel = 1 from the next edge, and go to REQ.
  - ack is ignored in IDLE.
- REQ:
  - Exactly one expsrc line is high; it holds while ack == 0. expblock rising in REQ does not withdraw the request.
  - On an edge with ack == 1: clear pending[sel], drive expsrc_sel = 0, increment req_cnt, go to WAIT_REL.
- WAIT_REL:
  - All expsrc lines are 0. Stay while ack == 1; go to IDLE on the first edge with ack == 0.
  - This guarantees a fresh rising edge on the CPU's edge-sensitive capture for each request.
- Simultaneous set and clear of pending[sel] on the same edge: set wins, so the new event stays pending.
- Pending is sticky; repeated events on an already-pending channel merge into one.
- sel is frozen in REQ. A higher-priority event arriving during REQ waits for the next IDLE.
- expblock high in IDLE: no transition, pending accumulates. Arbitration resumes the edge after expblock falls.
- req_cnt wraps 255 → 0.
- Invariant: at most one expsrc line is high at any time. busy = (state != IDLE).

Test Plan (DEBOUNCE_CYCLES=4):
- Single press: btn=001 held from before edge 1 → pending=001 after edge 6, expsrc0=1 after edge 7. Pulse ack for 1 cycle → expsrc0=0, pending=000, req_cnt=1; back in IDLE one edge after ack falls.
- Glitch rejection: btn[1] high for 3 cycles then low → pending stays 000, expsrc1 never rises. Held for 4+2 cycles → pending[1]=1.
- Priority: pending=110 in IDLE → expsrc1 first. After ack cycle and release, expsrc2 is raised next, and never both at once. req_cnt=2 after both acks.
- Ack held 3 cycles with pending=001 again → remains WAIT_REL; expsrc0 re-asserts only on the second edge after ack falls.
- Blocking: expblock=1, press btn[0] → pending=001, expsrc0=0, busy=0. Drop expblock → expsrc0=1 next edge.
- Reset mid-REQ: expsrc2=1, assert reset one cycle → all outputs 0 after that edge, req_cnt=0, and no request follows while btn is low.
